// File: rtl/parity_rx.sv
// parity_rx: serial frame receiver (start, DATA_W data LSB first, parity, stop)
// with a one-entry valid/ready output register.
// Optional build macro PARITY_RX_DROP_ERR_EN: discard frames with parity or stop errors.
module parity_rx #(
    parameter int DATA_W = 8,
    parameter int ODD    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_en,
    input  logic              rx,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    input  logic              ready,
    output logic              par_err,
    output logic              frm_err,
    output logic              overrun
);

    localparam int CW = $clog2(DATA_W) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [CW-1:0]     r_cnt;
    logic [DATA_W-1:0] r_shift;
    logic              r_acc;
    logic              r_perr;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_par_err;
    logic              r_frm_err;
    logic              r_overrun;

    logic              w_last_bit;
    logic              w_done;
    logic              w_ferr;
    logic              w_room;
    logic              w_keep;
    logic              w_load;
    logic              w_ovr;
    logic [DATA_W-1:0] w_shift_next;

    assign w_last_bit   = (r_cnt == CW'(DATA_W - 1));
    assign w_done       = bit_en && (r_state == S_STOP);
    assign w_ferr       = ~rx;
    assign w_room       = ~r_valid | ready;
    assign w_shift_next = (r_shift >> 1) | (DATA_W'(rx) << (DATA_W - 1));

`ifdef PARITY_RX_DROP_ERR_EN
    assign w_keep = ~(r_perr | w_ferr);
`else
    assign w_keep = 1'b1;
`endif

    assign w_load = w_done & w_keep & w_room;
    assign w_ovr  = w_done & w_keep & ~w_room;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: advance only on bit strobes
    always_comb begin
        w_next_state = r_state;
        if (bit_en) begin
            case (r_state)
                S_IDLE:  if (!rx) w_next_state = S_DATA;
                S_DATA:  if (w_last_bit) w_next_state = S_PAR;
                S_PAR:   w_next_state = S_STOP;
                S_STOP:  w_next_state = S_IDLE;
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // Deserializer: bit counter, shifter, running XOR and parity verdict
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_shift <= '0;
            r_acc   <= 1'b0;
            r_perr  <= 1'b0;
        end else if (bit_en) begin
            case (r_state)
                S_IDLE: begin
                    if (!rx) begin
                        r_cnt <= '0;
                        r_acc <= 1'b0;
                    end
                end
                S_DATA: begin
                    r_shift <= w_shift_next;
                    r_acc   <= r_acc ^ rx;
                    r_cnt   <= r_cnt + CW'(1);
                end
                S_PAR: begin
                    r_perr <= r_acc ^ rx ^ 1'(ODD);
                end
                default: ;
            endcase
        end
    end

    // Output register: load on completion if free, else flag overrun
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_par_err <= 1'b0;
            r_frm_err <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_ovr;
            if (w_load) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
`ifdef PARITY_RX_DROP_ERR_EN
                r_par_err <= 1'b0;
                r_frm_err <= 1'b0;
`else
                r_par_err <= r_perr;
                r_frm_err <= w_ferr;
`endif
            end else if (r_valid && ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data    = r_data;
    assign valid   = r_valid;
    assign par_err = r_par_err;
    assign frm_err = r_frm_err;
    assign overrun = r_overrun;

endmodule

// File: tb/tb_parity_rx.sv
// tb_parity_rx: directed vectors for parity_rx
// even instance plus odd instance on one line
module tb_parity_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_en;
  logic       rx;
  logic       ready;
  logic       ready_o;
  logic [7:0] data;
  logic       valid;
  logic       par_err;
  logic       frm_err;
  logic       overrun;
  logic [7:0] data_o;
  logic       valid_o;
  logic       par_err_o;
  logic       frm_err_o;
  logic       overrun_o;

  logic       p_hold = 1'b0;
  logic [7:0] p_data = '0;
  logic       p_perr = 1'b0;
  logic       p_ferr = 1'b0;
  logic       p_ovr  = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  parity_rx #(.DATA_W(8), .ODD(0)) u_even (
    .clk(clk), .rst(rst), .bit_en(bit_en), .rx(rx),
    .data(data), .valid(valid), .ready(ready),
    .par_err(par_err), .frm_err(frm_err),
    .overrun(overrun)
  );

  parity_rx #(.DATA_W(8), .ODD(1)) u_odd (
    .clk(clk), .rst(rst), .bit_en(bit_en), .rx(rx),
    .data(data_o), .valid(valid_o), .ready(ready_o),
    .par_err(par_err_o), .frm_err(frm_err_o),
    .overrun(overrun_o)
  );

  always @(posedge clk) begin
    if (!rst) begin
      if (p_hold) begin
        if (data !== p_data || par_err !== p_perr
            || frm_err !== p_ferr) begin
          n_fail++;
          $error("FAIL hold_stable data=%0h", data);
        end
      end
      if (overrun === 1'b1 && p_ovr === 1'b1) begin
        n_fail++;
        $error("FAIL ovr_two_cycles");
      end
    end
    p_hold <= !rst && valid && !ready;
    p_data <= data;
    p_perr <= par_err;
    p_ferr <= frm_err;
    p_ovr  <= rst ? 1'b0 : overrun;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  `define CK(t, o, e) check(t, 32'(o), 32'(e))

  task automatic send_bit(input logic b, input int gap);
    repeat (gap) @(negedge clk);
    rx     = b;
    bit_en = 1'b1;
    @(negedge clk);
    bit_en = 1'b0;
  endtask

  task automatic send_head(input logic [7:0] d, input logic p,
                           input int gap);
    logic [7:0] v;
    v = d;
    send_bit(1'b0, gap);
    for (int i = 0; i < 8; i++) send_bit(v[i], gap);
    send_bit(p, gap);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p,
                            input logic s, input int gap);
    send_head(d, p, gap);
    send_bit(s, gap);
  endtask

  task automatic drain();
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    bit_en  = 1'b0;
    rx      = 1'b1;
    ready   = 1'b0;
    ready_o = 1'b1;
    repeat (2) @(negedge clk);
    `CK("rst_data", data, 8'h00);
    `CK("rst_valid", valid, 1'b0);
    `CK("rst_perr", par_err, 1'b0);
    `CK("rst_ferr", frm_err, 1'b0);
    `CK("rst_ovr", overrun, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    send_frame(8'hA5, 1'b0, 1'b1, 3);
    `CK("a5_valid", valid, 1'b1);
    `CK("a5_data", data, 8'hA5);
    `CK("a5_perr", par_err, 1'b0);
    `CK("a5_ferr", frm_err, 1'b0);
    repeat (3) @(negedge clk);
    `CK("a5_hold", data, 8'hA5);
    drain();
    `CK("a5_clr", valid, 1'b0);

    send_frame(8'hA5, 1'b1, 1'b1, 3);
`ifdef PARITY_RX_DROP_ERR_EN
    `CK("a5p_valid", valid, 1'b0);
    `CK("a5p_ovr", overrun, 1'b0);
`else
    `CK("a5p_valid", valid, 1'b1);
    `CK("a5p_data", data, 8'hA5);
    `CK("a5p_perr", par_err, 1'b1);
    drain();
`endif

    send_frame(8'h3C, 1'b0, 1'b0, 3);
`ifdef PARITY_RX_DROP_ERR_EN
    `CK("3cf_valid", valid, 1'b0);
`else
    `CK("3cf_valid", valid, 1'b1);
    `CK("3cf_data", data, 8'h3C);
    `CK("3cf_ferr", frm_err, 1'b1);
    `CK("3cf_perr", par_err, 1'b0);
    drain();
`endif
    send_frame(8'h5A, 1'b0, 1'b1, 3);
    `CK("brk_valid", valid, 1'b1);
    `CK("brk_data", data, 8'h5A);
    `CK("brk_ferr", frm_err, 1'b0);
    drain();

    send_frame(8'h3C, 1'b0, 1'b1, 3);
    `CK("ov1_data", data, 8'h3C);
    send_frame(8'h5A, 1'b0, 1'b1, 3);
    `CK("ov_pulse", overrun, 1'b1);
    `CK("ov_data", data, 8'h3C);
    `CK("ov_valid", valid, 1'b1);
    @(negedge clk);
    `CK("ov_one", overrun, 1'b0);
    drain();
    `CK("ov_clr", valid, 1'b0);

    send_frame(8'h3C, 1'b0, 1'b1, 3);
    send_head(8'h5A, 1'b0, 3);
    repeat (3) @(negedge clk);
    ready = 1'b1;
    send_bit(1'b1, 0);
    ready = 1'b0;
    `CK("rc_data", data, 8'h5A);
    `CK("rc_valid", valid, 1'b1);
    `CK("rc_ovr", overrun, 1'b0);
    drain();

    ready = 1'b1;
    send_frame(8'h00, 1'b1, 1'b1, 3);
    `CK("odd1_valid", valid_o, 1'b1);
    `CK("odd1_perr", par_err_o, 1'b0);
    send_frame(8'h00, 1'b0, 1'b1, 3);
`ifdef PARITY_RX_DROP_ERR_EN
    `CK("odd0_valid", valid_o, 1'b0);
`else
    `CK("odd0_valid", valid_o, 1'b1);
    `CK("odd0_perr", par_err_o, 1'b1);
`endif
    @(negedge clk);
    ready = 1'b0;

    send_bit(1'b0, 3);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 3);
    rst = 1'b1;
    @(negedge clk);
    `CK("mid_valid", valid, 1'b0);
    `CK("mid_ovr", overrun, 1'b0);
    `CK("mid_data", data, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    send_frame(8'h81, 1'b0, 1'b1, 3);
    `CK("81_valid", valid, 1'b1);
    `CK("81_data", data, 8'h81);
    `CK("81_perr", par_err, 1'b0);
    `CK("81_ferr", frm_err, 1'b0);
    drain();

    send_frame(8'h81, 1'b0, 1'b1, 0);
    `CK("g0_valid", valid, 1'b1);
    `CK("g0_data", data, 8'h81);
    `CK("g0_perr", par_err, 1'b0);
    drain();
    send_frame(8'h81, 1'b0, 1'b1, 7);
    `CK("g7_valid", valid, 1'b1);
    `CK("g7_data", data, 8'h81);
    `CK("g7_perr", par_err, 1'b0);
    drain();
    `CK("g7_clr", valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
